// File: rtl/flip_domain_retimer_pkg.sv
// ----------------------------------------------------------------------------
// flip_domain_retimer_pkg
// Shared definitions for the inverted-clock retimer: the default word and
// counter widths, and the occupancy state type used by the skid buffer.
// ----------------------------------------------------------------------------
package flip_domain_retimer_pkg;

    localparam int FRTM_DATA_W = 8;
    localparam int FRTM_CNT_W  = 16;

    // Number of words currently held by the two-entry skid buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/flip_domain_retimer_skid_buffer.sv
// ----------------------------------------------------------------------------
// frtm_skid_buffer
// Two-entry skid buffer with an occupancy FSM. It accepts a word every cycle
// while fewer than two are held and presents the oldest word from a flop.
//
// Ports
//   i_clk     clock, all state changes on the rising edge
//   i_rst_n   synchronous reset, active low
//   i_flush   synchronous discard of all held words
//   i_valid   producer word valid
//   i_data    producer word
//   o_ready   buffer accepts a word this cycle (registered)
//   o_valid   head word available
//   o_data    head word
//   i_ready   consumer takes the head word
// ----------------------------------------------------------------------------
module frtm_skid_buffer
    import flip_domain_retimer_pkg::*;
#(
    parameter int DATA_W = FRTM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
);

    occ_state_t        r_state;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic              r_ready;

    occ_state_t        w_nextState;
    logic              w_push;
    logic              w_pop;
    logic              w_loadHeadIn;
    logic              w_loadTail;
    logic              w_headFromTail;

    assign w_push  = i_valid & r_ready;
    assign w_pop   = (r_state != OCC_EMPTY) & i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_state != OCC_EMPTY);
    assign o_data  = r_head;

    // Next occupancy and which register captures what. On a simultaneous
    // push and pop in ONE the incoming word replaces the head directly, so the
    // tail is only ever used when the consumer stalls.
    always_comb begin
        w_nextState    = r_state;
        w_loadHeadIn   = 1'b0;
        w_loadTail     = 1'b0;
        w_headFromTail = 1'b0;
        case (r_state)
            OCC_EMPTY: begin
                if (w_push) begin
                    w_nextState  = OCC_ONE;
                    w_loadHeadIn = 1'b1;
                end
            end
            OCC_ONE: begin
                if (w_push && w_pop) begin
                    w_loadHeadIn = 1'b1;
                end else if (w_push) begin
                    w_nextState = OCC_TWO;
                    w_loadTail  = 1'b1;
                end else if (w_pop) begin
                    w_nextState = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (w_pop) begin
                    w_nextState    = OCC_ONE;
                    w_headFromTail = 1'b1;
                end
            end
            default: begin
                w_nextState = OCC_EMPTY;
            end
        endcase
        // Flush drops everything, including a word arriving this cycle
        if (i_flush) begin
            w_nextState    = OCC_EMPTY;
            w_loadHeadIn   = 1'b0;
            w_loadTail     = 1'b0;
            w_headFromTail = 1'b0;
        end
    end

    // Ready is registered from the next occupancy so the producer sees a
    // clean flop output; it stays low through reset and rises one cycle later.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= OCC_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ready <= (w_nextState != OCC_TWO);
            if (w_loadHeadIn) begin
                r_head <= i_data;
            end else if (w_headFromTail) begin
                r_head <= r_tail;
            end
            if (w_loadTail) begin
                r_tail <= i_data;
            end
        end
    end

endmodule

// File: rtl/flip_domain_retimer.sv
// ----------------------------------------------------------------------------
// flip_domain_retimer
// Captures words launched from the inverted-clock (negedge) domain and
// re-times them into the main posedge domain through a two-entry skid
// buffer, counting words delivered downstream.
//
// Optional feature: define FLIP_DOMAIN_RETIMER_PARITY_EN to add an even
// parity check on accepted words with a sticky error flag.
//
// Ports
//   FRTM_CLOCK_50     main clock
//   FRTM_RESET_InLow  synchronous reset, active low
//   FRTM_Flush        synchronous flush of buffered words and the counter
//   FRTM_In_Valid     producer word valid
//   FRTM_In_Data      producer word
//   FRTM_In_Ready     a word can be accepted this cycle (registered)
//   FRTM_Out_Valid    head word available
//   FRTM_Out_Data     head word
//   FRTM_Out_Ready    consumer accepts the head word
//   FRTM_Count        words delivered since reset/flush (wraps)
//   FRTM_In_Parity    (parity build) even parity bit of FRTM_In_Data
//   FRTM_Parity_Err   (parity build) sticky parity mismatch flag
// ----------------------------------------------------------------------------
module flip_domain_retimer
    import flip_domain_retimer_pkg::*;
#(
    parameter int DATA_W = FRTM_DATA_W,
    parameter int CNT_W  = FRTM_CNT_W
) (
    input  logic              FRTM_CLOCK_50,
    input  logic              FRTM_RESET_InLow,
    input  logic              FRTM_Flush,
    input  logic              FRTM_In_Valid,
    input  logic [DATA_W-1:0] FRTM_In_Data,
    output logic              FRTM_In_Ready,
    output logic              FRTM_Out_Valid,
    output logic [DATA_W-1:0] FRTM_Out_Data,
    input  logic              FRTM_Out_Ready,
`ifdef FLIP_DOMAIN_RETIMER_PARITY_EN
    input  logic              FRTM_In_Parity,
    output logic              FRTM_Parity_Err,
`endif
    output logic [CNT_W-1:0]  FRTM_Count
);

    logic             w_pop;
    logic [CNT_W-1:0] r_count;

    frtm_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (FRTM_CLOCK_50),
        .i_rst_n (FRTM_RESET_InLow),
        .i_flush (FRTM_Flush),
        .i_valid (FRTM_In_Valid),
        .i_data  (FRTM_In_Data),
        .o_ready (FRTM_In_Ready),
        .o_valid (FRTM_Out_Valid),
        .o_data  (FRTM_Out_Data),
        .i_ready (FRTM_Out_Ready)
    );

    assign w_pop      = FRTM_Out_Valid & FRTM_Out_Ready;
    assign FRTM_Count = r_count;

    // Delivered-word counter; a pop in the same cycle as a flush is not counted
    always_ff @(posedge FRTM_CLOCK_50) begin
        if (!FRTM_RESET_InLow) begin
            r_count <= '0;
        end else if (FRTM_Flush) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef FLIP_DOMAIN_RETIMER_PARITY_EN
    logic w_push;
    logic w_parityBad;
    logic r_parityErr;

    assign w_push          = FRTM_In_Valid & FRTM_In_Ready;
    assign w_parityBad     = (^FRTM_In_Data) != FRTM_In_Parity;
    assign FRTM_Parity_Err = r_parityErr;

    // Sticky mismatch flag; the offending word is still stored normally
    always_ff @(posedge FRTM_CLOCK_50) begin
        if (!FRTM_RESET_InLow) begin
            r_parityErr <= 1'b0;
        end else if (FRTM_Flush) begin
            r_parityErr <= 1'b0;
        end else if (w_push && w_parityBad) begin
            r_parityErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_flip_domain_retimer.sv
// ----------------------------------------------------------------------------
// tb_flip_domain_retimer
// Self-checking bench: a queue-based model of the retimer is updated on every
// rising edge and compared with the DUT on every falling edge; directed
// sequences add literal expectations, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_flip_domain_retimer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rstN;
    logic              flush;
    logic              inValid;
    logic [DATA_W-1:0] inData;
    logic              inParity;
    logic              outReady;
    logic              dutInReady;
    logic              dutOutValid;
    logic [DATA_W-1:0] dutOutData;
    logic [CNT_W-1:0]  dutCount;
`ifdef FLIP_DOMAIN_RETIMER_PARITY_EN
    logic              dutParityErr;
`endif

    int errors = 0;
    int checks = 0;

    // Model state
    logic [DATA_W-1:0] mQ[$];
    logic [CNT_W-1:0]  mCount;
    bit                mReady;
    bit                mParErr;
    bit                modelLive = 1'b0;

    always #5 clk = ~clk;

    flip_domain_retimer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .FRTM_CLOCK_50    (clk),
        .FRTM_RESET_InLow (rstN),
        .FRTM_Flush       (flush),
        .FRTM_In_Valid    (inValid),
        .FRTM_In_Data     (inData),
        .FRTM_In_Ready    (dutInReady),
        .FRTM_Out_Valid   (dutOutValid),
        .FRTM_Out_Data    (dutOutData),
        .FRTM_Out_Ready   (outReady),
`ifdef FLIP_DOMAIN_RETIMER_PARITY_EN
        .FRTM_In_Parity   (inParity),
        .FRTM_Parity_Err  (dutParityErr),
`endif
        .FRTM_Count       (dutCount)
    );

    // Reference model: a FIFO of at most two words, a delivered counter and
    // a sticky parity flag, advanced with the inputs present at each edge.
    always @(posedge clk) begin
        bit doPush;
        bit doPop;
        if (!rstN) begin
            mQ.delete();
            mCount  = '0;
            mReady  = 1'b0;
            mParErr = 1'b0;
        end else if (flush) begin
            mQ.delete();
            mCount  = '0;
            mReady  = 1'b1;
            mParErr = 1'b0;
        end else begin
            doPush = inValid && mReady;
            doPop  = (mQ.size() != 0) && outReady;
            if (doPop) begin
                void'(mQ.pop_front());
                mCount = mCount + 1'b1;
            end
            if (doPush) begin
                mQ.push_back(inData);
                if ((^inData) != inParity) mParErr = 1'b1;
            end
            mReady = (mQ.size() < 2);
        end
        modelLive = 1'b1;
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (modelLive) begin
            checks++;
            if (dutInReady !== mReady) begin
                errors++;
                $display("[TB] FAIL inReady t=%0t actual=%b required=%b", $time, dutInReady, mReady);
            end
            checks++;
            if (dutOutValid !== (mQ.size() != 0)) begin
                errors++;
                $display("[TB] FAIL outValid t=%0t actual=%b required=%b", $time, dutOutValid, (mQ.size() != 0));
            end
            if (mQ.size() != 0) begin
                checks++;
                if (dutOutData !== mQ[0]) begin
                    errors++;
                    $display("[TB] FAIL outData t=%0t actual=%h required=%h", $time, dutOutData, mQ[0]);
                end
            end
            checks++;
            if (dutCount !== mCount) begin
                errors++;
                $display("[TB] FAIL count t=%0t actual=%0d required=%0d", $time, dutCount, mCount);
            end
`ifdef FLIP_DOMAIN_RETIMER_PARITY_EN
            checks++;
            if (dutParityErr !== mParErr) begin
                errors++;
                $display("[TB] FAIL parityErr t=%0t actual=%b required=%b", $time, dutParityErr, mParErr);
            end
`endif
        end
    end

    // Drive one cycle of inputs just after the falling edge (producer side)
    task automatic applyStimulus(input bit r, input bit f, input bit v,
                                 input logic [DATA_W-1:0] d, input bit ordy, input bit par);
        @(negedge clk);
        #1;
        rstN     = r;
        flush    = f;
        inValid  = v;
        inData   = d;
        outReady = ordy;
        inParity = par;
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0; inParity = 1'b0;

        // Reset held for three edges, then released
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        afterEdge();
        checkOutput("resetInReady", 32'(dutInReady), 32'd0);
        checkOutput("resetOutValid", 32'(dutOutValid), 32'd0);
        checkOutput("resetOutData", 32'(dutOutData), 32'd0);
        checkOutput("resetCount", 32'(dutCount), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        afterEdge();
        checkOutput("releaseInReady", 32'(dutInReady), 32'd1);

        // Full-throughput stream with one cycle latency
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b1, ^(8'(i)));
            afterEdge();
            checkOutput("streamData", 32'(dutOutData), 32'(i));
            checkOutput("streamValid", 32'(dutOutValid), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        afterEdge();
        checkOutput("streamCount", 32'(dutCount), 32'd16);
        checkOutput("streamDrained", 32'(dutOutValid), 32'd0);

        // Back-pressure: fill both entries, then drain
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1);
        afterEdge();
        checkOutput("fullInReady", 32'(dutInReady), 32'd0);
        checkOutput("fullHead", 32'(dutOutData), 32'hA1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        afterEdge();
        checkOutput("fullHeadStable", 32'(dutOutData), 32'hA1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        afterEdge();
        checkOutput("drainHead", 32'(dutOutData), 32'hA2);
        checkOutput("drainInReady", 32'(dutInReady), 32'd1);
        checkOutput("drainCount1", 32'(dutCount), 32'd17);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        afterEdge();
        checkOutput("drainCount2", 32'(dutCount), 32'd18);
        checkOutput("drainEmpty", 32'(dutOutValid), 32'd0);

        // Simultaneous push and pop while holding one word
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h54, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        afterEdge();
        checkOutput("swapHead", 32'(dutOutData), 32'h55);
        checkOutput("swapCount", 32'(dutCount), 32'd19);
        checkOutput("swapInReady", 32'(dutInReady), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with two words held, then flush overriding a real push and pop
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
        afterEdge();
        checkOutput("flushValid", 32'(dutOutValid), 32'd0);
        checkOutput("flushCount", 32'(dutCount), 32'd0);
        checkOutput("flushInReady", 32'(dutInReady), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 1'b1);
        afterEdge();
        checkOutput("flushPushDropped", 32'(dutOutValid), 32'd0);
        checkOutput("flushPopUncounted", 32'(dutCount), 32'd0);

`ifdef FLIP_DOMAIN_RETIMER_PARITY_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0);
        afterEdge();
        checkOutput("parityGood", 32'(dutParityErr), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1);
        afterEdge();
        checkOutput("parityBad", 32'(dutParityErr), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        afterEdge();
        checkOutput("paritySticky", 32'(dutParityErr), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        afterEdge();
        checkOutput("parityFlushed", 32'(dutParityErr), 32'd0);
`endif

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            logic [DATA_W-1:0] d;
            d = 8'($urandom);
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 3) != 0,
                          d,
                          $urandom_range(0, 2) != 0,
                          (^d) ^ ($urandom_range(0, 9) == 0));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
